// File: rtl/rv32i_types.sv
// Shared types for the data-memory responder: FSM states, the latched request, and the LFSR seed.
package rv32i_types;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dmem_resp_state_t;

    localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;

    // Request fields captured at acceptance. The word index is kept separately because its width follows DEPTH_LOG2.
    typedef struct packed {
        logic        is_write;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_lat_lfsr.sv
// Purpose: 8-bit Fibonacci LFSR (taps 8,6,5,4) that picks a per-access latency. Exists only with DMEM_RESPONDER_RANDLAT_EN.
// Latency: value is registered and steps on the edge where advance is high.
// Backpressure: none; it advances exactly once per accepted request.
`ifdef DMEM_RESPONDER_RANDLAT_EN
module lat_lfsr
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    output logic [7:0] value
);

    logic fb;

    assign fb = value[7] ^ value[5] ^ value[4] ^ value[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= DMEM_LFSR_SEED;
        end else if (advance) begin
            value <= {value[6:0], fb};
        end
    end

endmodule
`endif

// File: rtl/dmem_responder.sv
// Purpose: data-memory responder with a word array, fixed (or, with DMEM_RESPONDER_RANDLAT_EN, LFSR-chosen) access latency.
// Latency: request accepted in cycle 0, dmem_resp pulses in cycle LATENCY; each access occupies LATENCY+1 cycles.
// Backpressure: dmem_stall freezes the latency counter; dropping the request while busy aborts the access.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_stall,
    output logic        dmem_resp,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    dmem_resp_state_t       state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             lat_eff;
    dmem_req_t              req_q;
    logic [DEPTH_LOG2-1:0]  idx_q;
    logic                   req_vld;
    logic                   accept;
    logic                   complete;
    logic                   addr_unused;
    logic [31:0]            mem [WORDS];

    assign req_vld     = dmem_read | dmem_write;
    assign addr_unused = ^{dmem_address[31:DEPTH_LOG2+2], dmem_address[1:0]};

`ifdef DMEM_RESPONDER_RANDLAT_EN
    logic [7:0] lfsr_val;
    logic [3:0] lat_q;
    logic [3:0] lat_pick;
    logic       lfsr_unused;

    lat_lfsr u_lat_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (accept),
        .value   (lfsr_val)
    );

    assign lat_pick    = 4'(32'(lfsr_val[3:0]) % LATENCY + 1);
    assign lfsr_unused = ^lfsr_val[7:4];
    assign lat_eff     = lat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= 4'(LATENCY);
        end else if (accept) begin
            lat_q <= lat_pick;
        end
    end
`else
    assign lat_eff = 4'(LATENCY);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        complete  = 1'b0;
        dmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_resp = !req_vld;
                if (req_vld) begin
                    accept  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A withdrawn request aborts silently; nothing is written or captured.
                if (!req_vld) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (!dmem_stall) begin
                    if (cnt_q == lat_eff - 4'd1) begin
                        complete  = 1'b1;
                        dmem_resp = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            req_q      <= '0;
            idx_q      <= '0;
            dmem_rdata <= 32'h0;
            dmem_ready <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                // Simultaneous read and write is treated as a write.
                req_q.is_write <= dmem_write;
                req_q.be       <= dmem_byte_enable;
                req_q.wdata    <= dmem_wdata;
                idx_q          <= dmem_address[DEPTH_LOG2+1:2];
            end
            if (complete) begin
                if (req_q.is_write) begin
                    dmem_ready <= 1'b0;
                end else begin
                    dmem_rdata <= mem[idx_q];
                    dmem_ready <= 1'b1;
                end
            end
        end
    end

    // The array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (complete && req_q.is_write) begin
            for (int b = 0; b < 4; b++) begin
                if (req_q.be[b]) begin
                    mem[idx_q][8*b +: 8] <= req_q.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a queue-based scoreboard on completed accesses.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_wdata;
    logic        dmem_stall;
    logic        dmem_resp;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   pend;
    int   vectors;
    int   errors;

    dmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_stall       (dmem_stall),
        .dmem_resp        (dmem_resp),
        .dmem_ready       (dmem_ready),
        .dmem_rdata       (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the negedge after a completion cycle shows the registered rdata/ready.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL sb_underflow: completion with empty queue at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_rdata", dmem_rdata, mon_e.rdata);
                check("sb_ready", {31'b0, dmem_ready}, {31'b0, mon_e.ready});
            end
        end
        if (rst_n && (dmem_read || dmem_write) && dmem_resp) pend = 1'b1;
    end

    task automatic do_access(input bit wr, input bit rd, input logic [31:0] a, input logic [3:0] b,
                             input logic [31:0] d, input int stall_n,
                             input logic [31:0] exp_rd, input bit exp_rdy,
                             input logic [31:0] hold_rd, input bit hold_rdy);
        int n;
        exp_q.push_back('{rdata: exp_rd, ready: exp_rdy});
        @(posedge clk); #1;
        dmem_write       = wr;
        dmem_read        = rd;
        dmem_address     = a;
        dmem_byte_enable = b;
        dmem_wdata       = d;
        dmem_stall       = (stall_n > 0);
        n = 0;
        forever begin
            @(negedge clk);
            if (n >= 1 && n <= stall_n) begin
                check("stall_hold_rdata", dmem_rdata, hold_rd);
                check("stall_hold_ready", {31'b0, dmem_ready}, {31'b0, hold_rdy});
            end
            if (dmem_resp) break;
            if (n == 40) begin
                vectors++;
                errors++;
                $display("FAIL resp_timeout: no dmem_resp after %0d cycles, addr %h", n, a);
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > stall_n) dmem_stall = 1'b0;
        end
        check("resp_cycle", n, LAT + stall_n);
        @(posedge clk); #1;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        dmem_stall = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors          = 0;
        errors           = 0;
        pend             = 1'b0;
        rst_n            = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_byte_enable = '0;
        dmem_wdata       = '0;
        dmem_stall       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_resp", {31'b0, dmem_resp}, 32'd1);
        end
        check("reset_ready", {31'b0, dmem_ready}, 32'd0);
        check("reset_rdata", dmem_rdata, 32'h0);

        //        wr rd addr           be    wdata         stl exp_rdata     rdy hold
        do_access(1, 0, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 0, 32'h00000000, 0, 32'h0, 0);
        do_access(0, 1, 32'h0000_0010, 4'h0, 32'h0,       0, 32'hDEADBEEF, 1, 32'h0, 0);
        do_access(1, 0, 32'h0000_0010, 4'h2, 32'h00005500, 0, 32'hDEADBEEF, 0, 32'h0, 0);
        do_access(0, 1, 32'h0000_0010, 4'h0, 32'h0,       0, 32'hDEAD55EF, 1, 32'h0, 0);
        do_access(1, 0, 32'h0000_0014, 4'hF, 32'h12345678, 0, 32'hDEAD55EF, 0, 32'h0, 0);
        do_access(0, 1, 32'h0000_0010, 4'h0, 32'h0,       0, 32'hDEAD55EF, 1, 32'h0, 0);
        do_access(0, 1, 32'h0000_0014, 4'h0, 32'h0,       3, 32'h12345678, 1, 32'hDEAD55EF, 1);

        // Read withdrawn in the first busy cycle.
        @(posedge clk); #1;
        dmem_read    = 1'b1;
        dmem_address = 32'h0000_0010;
        @(negedge clk);
        check("abort_c0_resp", {31'b0, dmem_resp}, 32'd0);
        @(posedge clk); #1;
        dmem_read = 1'b0;
        @(negedge clk);
        check("abort_c1_resp", {31'b0, dmem_resp}, 32'd0);
        @(negedge clk);
        check("abort_idle_resp", {31'b0, dmem_resp}, 32'd1);
        check("abort_rdata", dmem_rdata, 32'h12345678);
        check("abort_ready", {31'b0, dmem_ready}, 32'd1);

        do_access(1, 0, 32'h0000_1010, 4'hF, 32'hCAFEF00D, 0, 32'h12345678, 0, 32'h0, 0);
        do_access(0, 1, 32'h0000_0010, 4'h0, 32'h0,       0, 32'hCAFEF00D, 1, 32'h0, 0);
        do_access(1, 1, 32'h0000_0014, 4'hF, 32'hA5A5A5A5, 0, 32'hCAFEF00D, 0, 32'h0, 0);
        do_access(0, 1, 32'h0000_0014, 4'h0, 32'h0,       0, 32'hA5A5A5A5, 1, 32'h0, 0);
        do_access(1, 0, 32'h0000_0014, 4'h0, 32'hFFFFFFFF, 0, 32'hA5A5A5A5, 0, 32'h0, 0);
        do_access(0, 1, 32'h0000_0014, 4'h0, 32'h0,       0, 32'hA5A5A5A5, 1, 32'h0, 0);

        // Reset pulsed in the first busy cycle of a write; the initiator drops its request with it.
        @(posedge clk); #1;
        dmem_write       = 1'b1;
        dmem_address     = 32'h0000_0014;
        dmem_byte_enable = 4'hF;
        dmem_wdata       = 32'h0;
        @(posedge clk); #1;
        rst_n      = 1'b0;
        dmem_write = 1'b0;
        #1;
        check("rst_resp", {31'b0, dmem_resp}, 32'd1);
        check("rst_ready", {31'b0, dmem_ready}, 32'd0);
        check("rst_rdata", dmem_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_access(0, 1, 32'h0000_0014, 4'h0, 32'h0,       0, 32'hA5A5A5A5, 1, 32'h0, 0);

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
